// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll scheduler.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    SETTLE,
    SHOW
  } state_t;

  localparam int DICE_W = 3;
  localparam logic [DICE_W-1:0] DICE_MIN = 3'd1;
  localparam logic [DICE_W-1:0] DICE_MAX = 3'd6;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises one raw button, debounces it and emits a one-cycle pulse
// when the debounced level rises.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // The counter only advances while the synchronised input disagrees with
  // the accepted level; any agreeing sample restarts the stability window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dice_roll_scheduler.sv
// Shares one dice datapath between several players: debounced requests,
// round-robin grant, timed spin, face capture and saturating scores.
module dice_roll_scheduler
  import dice_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int ROLL_CYCLES = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int SCORE_W     = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PLAYERS-1:0]         btn,
  input  logic [DICE_W-1:0]              dice_value,
  output logic                           roll_en,
  output logic [1:0]                     player_sel,
  output logic [DICE_W-1:0]              result,
  output logic                           result_valid,
  output logic                           busy,
  output logic [NUM_PLAYERS-1:0]         pending,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score
);

  localparam int CNT_MAX = (ROLL_CYCLES > HOLD_CYCLES) ? ROLL_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [NUM_PLAYERS-1:0]   rise;
  logic [NUM_PLAYERS-1:0]   req;
  logic [NUM_PLAYERS-1:0]   grant_mask;
  logic                     grant_valid;
  logic [1:0]               grant_idx;
  logic                     face_ok;
  logic [SCORE_W-1:0]       score_r [NUM_PLAYERS];

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [DICE_W-1:0]  d);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {{(SCORE_W + 1 - DICE_W){1'b0}}, d};
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .btn   (btn[g]),
      .rise  (rise[g])
    );
    assign score[g*SCORE_W +: SCORE_W] = score_r[g];
  end

  assign req     = pending | rise;
  assign face_ok = (dice_value >= DICE_MIN) && (dice_value <= DICE_MAX);

  // Fresh edges join the request set directly so an idle block grants one
  // cycle after the debounced edge; the scan descends so the nearest
  // requester after the last granted player wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (state == IDLE) begin
      for (int k = NUM_PLAYERS; k >= 1; k--) begin
        if (req[(int'(player_sel) + k) % NUM_PLAYERS]) begin
          grant_valid = 1'b1;
          grant_idx   = 2'((int'(player_sel) + k) % NUM_PLAYERS);
        end
      end
    end
  end

  assign grant_mask = grant_valid ? (NUM_PLAYERS'(1) << grant_idx) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      roll_en      <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      player_sel   <= '0;
      result       <= '0;
      pending      <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) score_r[i] <= '0;
    end else begin
      pending <= req & ~grant_mask;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state      <= ROLL;
            cnt        <= CNT_W'(ROLL_CYCLES - 1);
            roll_en    <= 1'b1;
            busy       <= 1'b1;
            player_sel <= grant_idx;
          end
        end
        ROLL: begin
          if (cnt == '0) begin
            state   <= SETTLE;
            roll_en <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SETTLE: begin
          if (face_ok) begin
            state        <= SHOW;
            result       <= dice_value;
            result_valid <= 1'b1;
            cnt          <= CNT_W'(HOLD_CYCLES - 1);
            for (int i = 0; i < NUM_PLAYERS; i++) begin
              if (player_sel == 2'(i)) score_r[i] <= sat_add(score_r[i], dice_value);
            end
          end else begin
            state   <= ROLL;
            roll_en <= 1'b1;
            cnt     <= '0;
          end
        end
        SHOW: begin
          if (cnt == '0) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Self-checking bench for dice_roll_scheduler: a behavioural model checked
// against the DUT every cycle, plus directed literal expectations.
module tb_dice_roll_scheduler;

  localparam int NP  = 2;
  localparam int DEB = 4;
  localparam int RC  = 8;
  localparam int HC  = 16;
  localparam int SW  = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [NP-1:0]   btn = '0;
  logic [2:0]      dice_value = 3'd1;
  logic            roll_en;
  logic [1:0]      player_sel;
  logic [2:0]      result;
  logic            result_valid;
  logic            busy;
  logic [NP-1:0]   pending;
  logic [NP*SW-1:0] score;

  always #5 clk = ~clk;

  dice_roll_scheduler #(
    .NUM_PLAYERS (NP),
    .DEB_CYCLES  (DEB),
    .ROLL_CYCLES (RC),
    .HOLD_CYCLES (HC),
    .SCORE_W     (SW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .dice_value   (dice_value),
    .roll_en      (roll_en),
    .player_sel   (player_sel),
    .result       (result),
    .result_valid (result_valid),
    .busy         (busy),
    .pending      (pending),
    .score        (score)
  );

  int checks = 0;
  int errors = 0;
  int roll_cnt = 0;
  int show_cnt = 0;
  int grants[$];
  bit prev_busy = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model phases: 0 idle, 1 spinning, 2 settle, 3 showing; m_left is cycles remaining.
  int       m_phase = 0;
  int       m_left = 0;
  int       m_sel = 0;
  int       m_result = 0;
  int       m_score[NP];
  bit [NP-1:0] m_pend = '0;
  bit [NP-1:0] m_rise = '0;
  bit [NP-1:0] m_level = '0;
  bit [NP-1:0] h1 = '0;
  bit [NP-1:0] h2 = '0;
  bit       win[NP][$];

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_sel = 0; m_result = 0;
    m_pend = '0; m_rise = '0; m_level = '0; h1 = '0; h2 = '0;
    for (int p = 0; p < NP; p++) begin
      m_score[p] = 0;
      win[p].delete();
    end
  endtask

  task automatic model_step();
    bit [NP-1:0] req;
    bit [NP-1:0] synced;
    bit found;
    bit all_new;
    int j;
    int d;
    req = m_pend | m_rise;
    m_pend = req;
    d = int'(dice_value);
    case (m_phase)
      0: begin
        found = 1'b0;
        for (int k = 1; k <= NP; k++) begin
          j = (m_sel + k) % NP;
          if (!found && req[j]) begin
            found = 1'b1;
            m_pend[j] = 1'b0;
            m_sel = j;
            m_phase = 1;
            m_left = RC;
          end
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
      2: begin
        if (d >= 1 && d <= 6) begin
          m_result = d;
          m_score[m_sel] = (m_score[m_sel] + d > (1 << SW) - 1) ? (1 << SW) - 1 : m_score[m_sel] + d;
          m_phase = 3;
          m_left = HC;
        end else begin
          m_phase = 1;
          m_left = 1;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_phase = 0;
      end
    endcase
    synced = h2;
    h2 = h1;
    h1 = btn;
    m_rise = '0;
    for (int p = 0; p < NP; p++) begin
      win[p].push_back(synced[p]);
      if (win[p].size() > DEB) void'(win[p].pop_front());
      if (win[p].size() == DEB) begin
        all_new = 1'b1;
        foreach (win[p][q]) if (win[p][q] == m_level[p]) all_new = 1'b0;
        if (all_new) begin
          m_level[p] = ~m_level[p];
          m_rise[p] = m_level[p];
          win[p].delete();
        end
      end
    end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) m_score[p] = 0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, plus turn statistics.
  initial begin
    logic [NP*SW-1:0] exp_score;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) exp_score[p*SW +: SW] = SW'(m_score[p]);
      check_output("roll_en", roll_en, (m_phase == 1));
      check_output("busy", busy, (m_phase != 0));
      check_output("result_valid", result_valid, (m_phase == 3));
      check_output("player_sel", player_sel, m_sel);
      check_output("result", result, m_result);
      check_output("pending", pending, m_pend);
      check_output("score", score, exp_score);
      if (roll_en) roll_cnt++;
      if (result_valid) show_cnt++;
      if (busy && !prev_busy) grants.push_back(int'(player_sel));
      prev_busy = busy;
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while ((busy || pending != '0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output({name, "_done_in_time"}, (n < 300), 1'b1);
  endtask

  task automatic apply_stimulus(input int p, input logic [2:0] d, input int hold);
    dice_value = d;
    roll_cnt = 0;
    show_cnt = 0;
    @(negedge clk); #2;
    btn[p] = 1'b1;
    repeat (hold) @(negedge clk);
    #2;
    btn[p] = 1'b0;
    wait_done("press");
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    #400000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    summary();
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit glitch_seen;
    repeat (3) @(negedge clk);
    check_output("reset_roll_en", roll_en, 0);
    check_output("reset_busy", busy, 0);
    check_output("reset_score", score, 0);
    check_output("reset_pending", pending, 0);
    #2 reset = 1'b1;

    // Build up a score, then reset in the middle of a spin.
    apply_stimulus(0, 3'd5, 10);
    check_output("first_score0", score[SW-1:0], 5);
    check_output("model_first_score0", m_score[0], 5);
    @(negedge clk); #2;
    btn[0] = 1'b1;
    n = 0;
    while (!roll_en && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_output("reach_roll", roll_en, 1);
    check_output("score0_before_reset", score[SW-1:0], 5);
    #2 reset = 1'b0;
    btn = '0;
    #1;
    check_output("async_roll_en", roll_en, 0);
    check_output("async_busy", busy, 0);
    check_output("async_score", score, 0);
    check_output("async_player_sel", player_sel, 0);
    check_output("async_result", result, 0);
    check_output("async_result_valid", result_valid, 0);
    check_output("async_pending", pending, 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;

    // Single press, face 4.
    apply_stimulus(0, 3'd4, 10);
    check_output("single_roll_cycles", roll_cnt, 8);
    check_output("single_show_cycles", show_cnt, 16);
    check_output("single_result", result, 4);
    check_output("single_player_sel", player_sel, 0);
    check_output("single_score0", score[SW-1:0], 4);

    // Two-cycle glitch must not register.
    @(negedge clk); #2;
    btn[1] = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    btn[1] = 1'b0;
    glitch_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy || pending != '0) glitch_seen = 1'b1;
    end
    check_output("glitch_ignored", glitch_seen, 0);

    // Simultaneous presses after player 0 was served: player 1 first.
    grants.delete();
    dice_value = 3'd2;
    @(negedge clk); #2;
    btn = 2'b11;
    repeat (10) @(negedge clk);
    check_output("both_first_sel", player_sel, 1);
    check_output("both_pending_during_p1", pending, 2'b01);
    #2;
    btn = 2'b00;
    wait_done("both");
    check_output("both_grant_count", grants.size(), 2);
    if (grants.size() == 2) begin
      check_output("both_grant0", grants[0], 1);
      check_output("both_grant1", grants[1], 0);
    end
    check_output("both_score1", score[2*SW-1:SW], 2);
    check_output("both_score0", score[SW-1:0], 6);

    // Illegal face 7 forces one extra spin cycle, then 3 is taken.
    fork
      apply_stimulus(1, 3'd7, 10);
      begin
        int w = 0;
        while (!roll_en && w < 100) begin @(negedge clk); w++; end
        while (roll_en && w < 200) begin @(negedge clk); w++; end
        check_output("retry_settle_found", (w < 200), 1'b1);
        @(negedge clk); #2;
        dice_value = 3'd3;
      end
    join
    check_output("retry_roll_cycles", roll_cnt, 9);
    check_output("retry_show_cycles", show_cnt, 16);
    check_output("retry_result", result, 3);
    check_output("retry_score1", score[2*SW-1:SW], 5);

    // Saturation of player 0's score.
    for (int r = 0; r < 40; r++) apply_stimulus(0, 3'd6, 10);
    check_output("sat_score0_246", score[SW-1:0], 246);
    apply_stimulus(0, 3'd4, 10);
    check_output("sat_score0_250", score[SW-1:0], 250);
    apply_stimulus(0, 3'd6, 10);
    check_output("sat_score0_255", score[SW-1:0], 255);
    check_output("model_sat_255", m_score[0], 255);
    apply_stimulus(0, 3'd2, 10);
    check_output("sat_score0_hold", score[SW-1:0], 255);
    check_output("sat_result", result, 2);
    check_output("sat_score1_untouched", score[2*SW-1:SW], 5);

    summary();
    $finish;
  end

endmodule
